// File: rtl/ifetch_if.sv
// Bundle of the ROM read port, redirect request and decode-side valid/ready
// handshake seen by the instruction fetch stage.
interface ifetch_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_dout;
  logic                  redirect_valid;
  logic [ADDR_WIDTH+1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH+1:0] out_pc;

  // master is the fetch stage itself; slave is the ROM/decode/redirect side.
  modport master (
    output rom_addr, out_valid, out_instr, out_pc,
    input  rom_dout, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc,
    output rom_dout, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, reads a one-cycle synchronous ROM and
// buffers returned words in a 2-entry FIFO presented to decode via valid/ready.
module ifetch #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH+1:0] RESET_PC   = '0
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] RESET_WORD = RESET_PC[ADDR_WIDTH+1:2];

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [ADDR_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] push_slot;
  logic [1:0] unused_redirect_bits;

  assign unused_redirect_bits = bus.redirect_pc[1:0];

  // Credit rule: only issue if the word returning next cycle is sure to have
  // a free FIFO slot, counting words already buffered or in flight.
  always_comb begin
    pop       = (count_q != 2'd0) && bus.out_ready && !bus.redirect_valid;
    push      = inflight_q && !bus.redirect_valid;
    occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue     = !bus.redirect_valid && (occupancy < 3'd2);
    push_slot = count_q - 2'(pop);

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    instr0_d      = instr0_q;
    instr1_d      = instr1_q;
    pc0_d         = pc0_q;
    pc1_d         = pc1_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc[ADDR_WIDTH+1:2];
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(1);
      end
      count_d = count_q + 2'(push) - 2'(pop);
      if (pop) begin
        instr0_d = instr1_q;
        pc0_d    = pc1_q;
      end
      // The new word lands after whatever survives this cycle's pop.
      if (push) begin
        if (push_slot == 2'd0) begin
          instr0_d = bus.rom_dout;
          pc0_d    = inflight_pc_q;
        end else begin
          instr1_d = bus.rom_dout;
          pc1_d    = inflight_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_WORD;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      instr0_q      <= '0;
      instr1_q      <= '0;
      pc0_q         <= '0;
      pc1_q         <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      instr0_q      <= instr0_d;
      instr1_q      <= instr1_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
    end
  end

  assign bus.rom_addr  = fetch_pc_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = instr0_q;
  assign bus.out_pc    = {pc0_q, 2'b00};

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a 9-bit instance (RESET_PC 0x010) for the main
// scenarios and a 4-bit instance for PC wrap-around, each with a behavioural ROM.
module tb_ifetch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ifetch_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();
  ifetch_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_w ();

  ifetch #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RESET_PC(11'h010)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ifetch #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RESET_PC(6'h00)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w)
  );

  // ROM word k holds 0x1000_0000 + k, with a one-cycle registered read.
  always @(posedge clk) begin
    bus.rom_dout   <= 32'h1000_0000 + 32'(bus.rom_addr);
    bus_w.rom_dout <= 32'h1000_0000 + 32'(bus_w.rom_addr);
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [10:0] exp_pc;
  logic [43:0] got, want;
  logic [38:0] got_w, want_w;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;   bus.redirect_pc = '0;   bus.out_ready = 1'b1;
    bus_w.redirect_valid = 1'b0; bus_w.redirect_pc = '0; bus_w.out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    // Now in cycle r+1: reset state visible, first issue happening.
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    vectors++;
    if (got !== 44'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", got, 44'h0);
    end
    vectors++;
    if (bus.rom_addr !== 9'h004) begin
      miscompares++;
      $display("[TB] FAIL reset_rom_addr: got %h expected 004", bus.rom_addr);
    end
    tick;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 9'h005) begin
      miscompares++;
      $display("[TB] FAIL reset_r2: got valid=%b addr=%h expected valid=0 addr=005",
               bus.out_valid, bus.rom_addr);
    end
    tick;
    exp_pc = 11'h010;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h010, 32'h1000_0004};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL reset_first_pair: got %h expected %h", got, want);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp_pc = exp_pc + 11'd4;
      got  = {bus.out_valid, bus.out_pc, bus.out_instr};
      want = {1'b1, exp_pc, 32'h1000_0000 + 32'(exp_pc >> 2)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL stream_pair%0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] frozen;
    // Head is word exp_pc/4, one word in flight, fetch_pc two words ahead.
    frozen = 9'(exp_pc >> 2) + 9'd2;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got  = {bus.out_valid, bus.out_pc, bus.out_instr};
      want = {1'b1, exp_pc, 32'h1000_0000 + 32'(exp_pc >> 2)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: got %h expected %h", i, got, want);
      end
      vectors++;
      if (bus.rom_addr !== frozen) begin
        miscompares++;
        $display("[TB] FAIL bp_rom_addr%0d: got %h expected %h", i, bus.rom_addr, frozen);
      end
      tick;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got  = {bus.out_valid, bus.out_pc, bus.out_instr};
      want = {1'b1, exp_pc, 32'h1000_0000 + 32'(exp_pc >> 2)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL bp_resume%0d: got %h expected %h", i, got, want);
      end
      tick;
      exp_pc = exp_pc + 11'd4;
    end
  endtask

  task automatic test_redirect_full;
    bus.out_ready = 1'b0;
    tick;
    tick;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL redir_full_setup: got valid=%b expected 1", bus.out_valid);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 11'h100;
    bus.out_ready      = 1'b1;
    tick;
    bus.redirect_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 9'h040) begin
      miscompares++;
      $display("[TB] FAIL redir_t1: got valid=%b addr=%h expected valid=0 addr=040",
               bus.out_valid, bus.rom_addr);
    end
    tick;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL redir_t2: got valid=%b expected 0", bus.out_valid);
    end
    tick;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h100, 32'h1000_0040};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL redir_t3: got %h expected %h", got, want);
    end
    tick;
    exp_pc = 11'h104;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h104, 32'h1000_0041};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL redir_t4: got %h expected %h", got, want);
    end
  endtask

  task automatic test_back_to_back;
    // First redirect coincides with a valid head and out_ready high.
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 11'h104) begin
      miscompares++;
      $display("[TB] FAIL b2b_setup: got valid=%b pc=%h expected valid=1 pc=104",
               bus.out_valid, bus.out_pc);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 11'h040;
    tick;
    bus.redirect_pc = 11'h080;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 9'h010) begin
      miscompares++;
      $display("[TB] FAIL b2b_t1: got valid=%b addr=%h expected valid=0 addr=010",
               bus.out_valid, bus.rom_addr);
    end
    tick;
    bus.redirect_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 9'h020) begin
      miscompares++;
      $display("[TB] FAIL b2b_t2: got valid=%b addr=%h expected valid=0 addr=020",
               bus.out_valid, bus.rom_addr);
    end
    tick;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_t3: got valid=%b expected 0", bus.out_valid);
    end
    tick;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h080, 32'h1000_0020};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h expected %h", got, want);
    end
    tick;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h084, 32'h1000_0021};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h expected %h", got, want);
    end
  endtask

  task automatic test_wrap;
    logic [5:0]  wrap_pc[3];
    logic [31:0] wrap_instr[3];
    wrap_pc[0] = 6'h3C; wrap_instr[0] = 32'h1000_000F;
    wrap_pc[1] = 6'h00; wrap_instr[1] = 32'h1000_0000;
    wrap_pc[2] = 6'h04; wrap_instr[2] = 32'h1000_0001;
    bus_w.redirect_valid = 1'b1;
    bus_w.redirect_pc    = 6'h3C;
    tick;
    bus_w.redirect_valid = 1'b0;
    vectors++;
    if (bus_w.out_valid !== 1'b0 || bus_w.rom_addr !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL wrap_t1: got valid=%b addr=%h expected valid=0 addr=f",
               bus_w.out_valid, bus_w.rom_addr);
    end
    tick;
    vectors++;
    if (bus_w.out_valid !== 1'b0 || bus_w.rom_addr !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL wrap_t2: got valid=%b addr=%h expected valid=0 addr=0",
               bus_w.out_valid, bus_w.rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      got_w  = {bus_w.out_valid, bus_w.out_pc, bus_w.out_instr};
      want_w = {1'b1, wrap_pc[i], wrap_instr[i]};
      vectors++;
      if (got_w !== want_w) begin
        miscompares++;
        $display("[TB] FAIL wrap_pair%0d: got %h expected %h", i, got_w, want_w);
      end
    end
  endtask

  task automatic test_mid_reset;
    bus.out_ready = 1'b0;
    tick;
    tick;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mrst_setup: got valid=%b expected 1", bus.out_valid);
    end
    // Reset must win over a simultaneous redirect.
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 11'h100;
    tick;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    got = {bus.out_valid, bus.out_pc, bus.out_instr};
    vectors++;
    if (got !== 44'h0 || bus.rom_addr !== 9'h004) begin
      miscompares++;
      $display("[TB] FAIL mrst_r1: got %h addr=%h expected 0 addr=004", got, bus.rom_addr);
    end
    tick;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mrst_r2: got valid=%b expected 0", bus.out_valid);
    end
    tick;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h010, 32'h1000_0004};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL mrst_r3: got %h expected %h", got, want);
    end
    tick;
    got  = {bus.out_valid, bus.out_pc, bus.out_instr};
    want = {1'b1, 11'h014, 32'h1000_0005};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL mrst_r4: got %h expected %h", got, want);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_full;
    test_back_to_back;
    test_wrap;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage that sits directly upstream of the synchronous instruction ROM (one-cycle registered read). It owns the program counter, drives the ROM word address, and captures each returned word with its PC tag into a 2-entry buffer. It presents instruction/PC pairs to decode over a valid/ready handshake and handles PC redirects from branches and jumps by flushing everything in flight.

## Interface
- ADDR_WIDTH, 9: ROM word-address width; ROM depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: instruction width; must match ROM DATA_WIDTH.
- RESET_PC, 0: byte address fetched first after reset; bits [1:0] ignored.

Ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_WIDTH  word address to ROM; equals the fetch_pc register.
- rom_dout  in  DATA_WIDTH  ROM read data, valid the cycle after the address is presented.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH+2  byte target; bits [1:0] ignored.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  DATA_WIDTH  instruction at the buffer head.
- out_pc  out  ADDR_WIDTH+2  byte PC of out_instr, {word_pc, 2'b00}.

## Operation
- State:
  - fetch_pc: ADDR_WIDTH word PC.
  - inflight flag plus inflight_pc tag.
  - 2-entry FIFO of {instr, word_pc} with count 0..2.
- pop = out_valid && out_ready && !redirect_valid.
- issue = !redirect_valid && (count + inflight − pop) < 2.
- When issue is asserted:
  - inflight ← 1 and inflight_pc ← fetch_pc.
  - fetch_pc ← fetch_pc + 1, wrapping 2^ADDR_WIDTH−1 → 0.
- When issue is not asserted: inflight ← 0 and fetch_pc holds.
- rom_addr = fetch_pc every cycle. The ROM reads each cycle regardless; rom_dout from non-issue cycles is ignored.
- Response: if inflight = 1 and there is no redirect, {rom_dout, inflight_pc} is pushed at the tail this cycle. The issue credit rule guarantees the FIFO never overflows.
- Push and pop in the same cycle are legal, including at count = 1 and count = 2.
- Redirect (redirect_valid = 1), with priority over issue, push and pop:
  - count ← 0 and inflight ← 0; the rom_dout arriving this cycle is discarded.
  - fetch_pc ← redirect_pc[ADDR_WIDTH+1:2].
  - No issue occurs this cycle.
  - An out_valid && out_ready coincident with a redirect is void: not a transfer.
- Back-to-back redirects: the last one wins; each restarts the sequence.
- out_valid = (count != 0). out_instr and out_pc come from the head entry register, with no combinational path from rom_dout.
- Reset (rst = 1) dominates redirect and all handshakes:
  - fetch_pc ← RESET_PC[ADDR_WIDTH+1:2].
  - count ← 0, inflight ← 0, FIFO storage ← 0.
- Reset values:
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - rom_addr = RESET_PC >> 2.
- Reset asserted mid-stream discards all buffered and in-flight words. No partial pair is ever presented.

## Timing
- Fetch-to-output latency is 2 cycles: address issued in cycle c, rom_dout valid at c+1, out_valid at c+2.
- After rst deasserts (last reset cycle r):
  - First issue is at r+1.
  - out_valid is first asserted at r+3 with out_pc = RESET_PC.
- Redirect in cycle t:
  - out_valid = 0 at t+1 and t+2.
  - Target issued at t+1; target instruction on the outputs at t+3.
  - 2-cycle bubble beyond normal latency.
- Throughput: with out_ready held high, one instruction per cycle in steady state, with consecutive out_pc values differing by 4.
- Backpressure:
  - When out_ready drops, at most 2 words accumulate and issue stops.
  - fetch_pc holds, so rom_addr stays constant.
  - When out_ready returns, the output resumes in order with no gaps or duplicates.
- out_valid, once asserted, stays asserted with stable out_instr and out_pc until pop, redirect or rst.

## Test plan
- Reset, RESET_PC = 0x010, ROM word k = 0x1000_0000 + k, out_ready = 1 → out_valid rises at r+3. Pairs are (0x010, 0x1000_0004), (0x014, 0x1000_0005), … one per cycle.
- Backpressure: out_ready = 0 for 5 cycles mid-stream → count saturates at 2 and rom_addr is frozen. On release the sequence continues with no missing or repeated PC.
- Redirect to 0x100 while count = 2 and inflight = 1 → out_valid is 0 at t+1 and t+2. At t+3, out_pc = 0x100 and out_instr = 0x1000_0040. No stale pair appears.
- Redirect coincident with out_valid && out_ready → that head is not counted as transferred. Redirect in two consecutive cycles (0x040, then 0x080) → the first output is 0x080.
- Wrap: ADDR_WIDTH = 4, redirect to 0x03C → out_pc sequence 0x03C, 0x000, 0x004 with the matching ROM words.
- rst asserted for 1 cycle while 2 words are buffered → out_valid = 0 the next cycle. The restart from RESET_PC follows the reset latency above.
